// File: rtl/mul_div_unit_pkg.sv
// Shared datapath definitions for the multiply/divide unit: operation codes,
// FSM states and small op-decoding helpers.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'b000,
      MDU_MULTU = 3'b001,
      MDU_DIV   = 3'b010,
      MDU_DIVU  = 3'b011,
      MDU_MTHI  = 3'b100,
      MDU_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mdu_state_e;

   function automatic logic is_muldiv(input logic [2:0] op);
      return op[2] == 1'b0;
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op[2] == 1'b0) && (op[0] == 1'b0);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op[2] == 1'b0) && op[1];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide
// (shift-subtract) on the shared {acc_hi, acc_lo} working register pair.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   // NOTE: every variable is assigned before any branch, so no latch is inferred.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, opnd});
      diff    = shifted[WIDTH-1:0] - opnd;
      nxt_hi  = sum[WIDTH:1];
      nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
      // A successful trial subtraction always leaves less than the divisor,
      // so the low WIDTH bits of the difference hold the whole remainder.
      if (is_div) begin
         nxt_hi = fits ? diff : shifted[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], fits};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: WIDTH calculation cycles on operand
// magnitudes, one sign-fix cycle, one done cycle; mthi/mtlo write directly.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mdu_state_e         state, state_nxt;
   mdu_op_e            op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   cnt;
   logic               load_en, step_en, fix_en, mthi_en, mtlo_en;
   logic               sgn_q, div_q, neg_a, neg_b;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign sgn_q = is_signed_op(op_q);
   assign div_q = is_div_op(op_q);
   assign neg_a = sgn_q & a_q[WIDTH-1];
   assign neg_b = sgn_q & b_q[WIDTH-1];
   assign opnd  = div_q ? mag(b_q, sgn_q) : mag(a_q, sgn_q);

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div (div_q),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opnd   (opnd),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && is_muldiv(op)) state_nxt = ST_CALC;
         ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: state_nxt = (start && is_muldiv(op)) ? ST_CALC : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      load_en = 1'b0;
      step_en = 1'b0;
      fix_en  = 1'b0;
      mthi_en = 1'b0;
      mtlo_en = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            done    = (state == ST_DONE);
            load_en = start && is_muldiv(op);
            mthi_en = start && (op == MDU_MTHI);
            mtlo_en = start && (op == MDU_MTLO);
         end
         ST_CALC: begin
            busy    = 1'b1;
            step_en = 1'b1;
         end
         ST_FIX: begin
            busy   = 1'b1;
            fix_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Signed overflow (most negative / -1) needs no special case: the magnitude
   // quotient 2^(WIDTH-1) keeps its positive sign and reads back as itself.
   always_comb begin
      prod   = {acc_hi, acc_lo};
      res_hi = acc_hi;
      res_lo = acc_lo;
      if (!div_q) begin
         if (neg_a ^ neg_b) prod = -prod;
         {res_hi, res_lo} = prod;
      end else if (b_q == '0) begin
         res_hi = a_q;
         res_lo = '1;
      end else begin
         res_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
         res_hi = neg_a ? -acc_hi : acc_hi;
      end
   end

   // NOTE: latched operands and the working registers are reset too, so an
   // abandoned operation leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= MDU_MULT;
         a_q    <= '0;
         b_q    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
      end else if (load_en) begin
         op_q   <= mdu_op_e'(op);
         a_q    <= a;
         b_q    <= b;
         acc_hi <= '0;
         acc_lo <= is_div_op(op) ? mag(a, is_signed_op(op)) : mag(b, is_signed_op(op));
         cnt    <= '0;
      end else if (step_en) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (fix_en) begin
         hi <= res_hi;
         lo <= res_lo;
      end else begin
         if (mthi_en) hi <= a;
         if (mtlo_en) lo <= a;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random and directed ops are checked
// against an arithmetic reference model by a monitor that fires on done.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int W = 32;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op    = 3'b000;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t         exp_q[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Reference model: plain SV arithmetic on the architectural rules.
   function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t           r;
      longint         p;
      longint unsigned pu;
      r.hi = '0;
      r.lo = '0;
      case (o)
         MDU_MULT: begin
            p    = longint'($signed(x)) * longint'($signed(y));
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         MDU_MULTU: begin
            pu   = {32'b0, x} * {32'b0, y};
            r.hi = pu[63:32];
            r.lo = pu[31:0];
         end
         MDU_DIV: begin
            if (y == 0) begin
               r.hi = x;
               r.lo = '1;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r.hi = '0;
               r.lo = 32'h8000_0000;
            end else begin
               r.lo = $signed(x) / $signed(y);
               r.hi = $signed(x) % $signed(y);
            end
         end
         MDU_DIVU: begin
            if (y == 0) begin
               r.hi = x;
               r.lo = '1;
            end else begin
               r.lo = x / y;
               r.hi = x % y;
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      res_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, want no pending op");
         end else begin
            e = exp_q.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
         end
      end
   end

   // Each call ends at a negedge; b2b drives the next start on that same
   // negedge (i.e. while the previous op is in DONE).
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit b2b, input bit junk);
      int   lat;
      bit   seen;
      res_t e;
      if (!b2b) @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (o[2] == 1'b0) begin
         e = model(o, x, y);
         exp_q.push_back(e);
      end
      @(posedge clk);
      lat = 1;
      if (o[2] == 1'b1) begin
         @(negedge clk);
         start = 1'b0;
         if (o == MDU_MTHI) m_hi = x;
         else               m_lo = x;
         check("mt_hi", hi, m_hi);
         check("mt_lo", lo, m_lo);
         check("mt_busy", 32'(busy), 32'd0);
         check("mt_done", 32'(done), 32'd0);
         return;
      end
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (lat == 10) begin
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            check("busy_calc", 32'(busy), 32'd1);
         end
         if (junk && busy) begin
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         lat++;
      end
      start = 1'b0;
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done in 100 cycles, want done at cycle %0d", W + 2);
         return;
      end
      check("latency", 32'(lat), 32'(W + 2));
      check("done_busy", 32'(busy), 32'd0);
      m_hi = e.hi;
      m_lo = e.lo;
   endtask

   task automatic run_reserved(input logic [2:0] o);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = $urandom;
      b     = $urandom;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rsv_hi", hi, m_hi);
      check("rsv_lo", lo, m_lo);
      check("rsv_busy", 32'(busy), 32'd0);
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0] ro;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("multu_ff_hi", hi, 32'hFFFF_FFFE);
      check("multu_ff_lo", lo, 32'h0000_0001);
      run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFEB);
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);
      run_op(MDU_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
      check("divu_zero_lo", lo, 32'hFFFF_FFFF);
      check("divu_zero_hi", hi, 32'd7);
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'd0);
      run_op(MDU_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);

      run_op(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
      check("mthi_idle", hi, 32'h1234_5678);
      run_op(MDU_MULT, 32'd1000, 32'hFFFF_FFF6, 1'b1, 1'b1);
      run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
      run_op(MDU_MTLO, 32'h55, 32'd0, 1'b1, 1'b0);
      run_op(MDU_DIV, 32'd100, 32'hFFFF_FFF7, 1'b1, 1'b0);
      run_op(MDU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
      run_reserved(3'b110);
      run_reserved(3'b111);

      // Reset in the middle of a calculation.
      run_op(MDU_MTLO, 32'hAA, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      op    = MDU_MULT;
      a     = 32'd12345;
      b     = 32'd678;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_hi", hi, 32'd0);
      check("mid_rst_lo", lo, 32'd0);
      m_hi = '0;
      m_lo = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_op(MDU_DIVU, 32'd1_000_000, 32'd37, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 6));
         if (ro == 3'b110) run_reserved(3'($urandom_range(6, 7)));
         else run_op(ro, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
      end

      repeat (40) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
